// File: rtl/mem_access_ctrl_pkg.sv
// Shared LC-3b types for the memory access controller.
//   lc3b_word      : 16-bit machine word
//   lc3b_mem_op    : memory operation carried in the EX/MEM register
//   lc3b_mem_state : controller FSM state encoding
// Helper functions classify an op by the kind of first access it issues.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [2:0] {
    MEM_NONE = 3'd0,
    MEM_LDW  = 3'd1,
    MEM_LDB  = 3'd2,
    MEM_STW  = 3'd3,
    MEM_STB  = 3'd4,
    MEM_LDI  = 3'd5,
    MEM_STI  = 3'd6
  } lc3b_mem_op;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_INDIRECT = 2'd1,
    ST_DONE     = 2'd2
  } lc3b_mem_state;

  // STI fetches its pointer with a read first, so it counts as a read here.
  function automatic logic first_is_read(input lc3b_mem_op op);
    return (op == MEM_LDW) || (op == MEM_LDB) || (op == MEM_LDI) || (op == MEM_STI);
  endfunction

  function automatic logic first_is_write(input lc3b_mem_op op);
    return (op == MEM_STW) || (op == MEM_STB);
  endfunction

  function automatic logic is_indirect(input lc3b_mem_op op);
    return (op == MEM_LDI) || (op == MEM_STI);
  endfunction

  // Ops whose first (and only) access produces load_data.
  function automatic logic is_direct_load(input lc3b_mem_op op);
    return (op == MEM_LDW) || (op == MEM_LDB);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the access controller (master) and memory (slave).
//   dmem_read/dmem_write : request strobes, held until dmem_resp
//   dmem_address         : word-aligned address
//   dmem_wdata           : store data (byte lanes already steered)
//   dmem_byte_enable     : {high, low} byte write enables
//   dmem_rdata           : read data, valid with dmem_resp
//   dmem_resp            : access complete this cycle
interface mem_access_ctrl_if;
  import lc3b_types::*;

  logic        dmem_read;
  logic        dmem_write;
  lc3b_word    dmem_address;
  lc3b_word    dmem_wdata;
  logic [1:0]  dmem_byte_enable;
  lc3b_word    dmem_rdata;
  logic        dmem_resp;

  modport master (
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    output dmem_rdata, dmem_resp
  );

endinterface

// File: rtl/mem_access_ctrl_byte_lane.sv
// Combinational byte-lane steering for the memory access controller.
//   mem_op      : current memory op
//   byte_sel    : address bit 0 (1 = high byte)
//   wdata       : store source value
//   rdata       : raw word read from memory
//   lane_wdata  : store data with the byte replicated on both lanes for STB
//   byte_enable : write enables (single lane for STB, both otherwise)
//   lane_rdata  : read word, or the selected byte sign-extended for LDB
module mem_byte_lane
  import lc3b_types::*;
(
  input  lc3b_mem_op  mem_op,
  input  logic        byte_sel,
  input  lc3b_word    wdata,
  input  lc3b_word    rdata,
  output lc3b_word    lane_wdata,
  output logic [1:0]  byte_enable,
  output lc3b_word    lane_rdata
);

  function automatic lc3b_word sext8(input logic signed [7:0] b);
    logic signed [15:0] w;
    w = 16'(b);
    return w;
  endfunction

  always_comb begin
    lane_wdata  = wdata;
    byte_enable = 2'b11;
    lane_rdata  = rdata;
    if (mem_op == MEM_STB) begin
      lane_wdata  = {wdata[7:0], wdata[7:0]};
      byte_enable = byte_sel ? 2'b10 : 2'b01;
    end
    if (mem_op == MEM_LDB) begin
      lane_rdata = sext8(byte_sel ? rdata[15:8] : rdata[7:0]);
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// LC-3b MEM-stage access controller. Issues the data-memory access for the
// op in EX/MEM, performs the second access of LDI/STI through a latched
// pointer, and stalls the pipeline until the access sequence completes.
//   clk, reset     : clock, synchronous active-high reset
//   mem_op         : memory op from EX/MEM
//   address, wdata : effective address and store source value
//   hold           : pipeline frozen by another stall source
//   dmem           : data-memory bus (master side)
//   load_data      : registered load result for MEM/WB
//   done           : access finished, load_data valid
//   stall_pipeline : freeze all pipeline registers
module mem_access_ctrl
  import lc3b_types::*;
(
  input  logic               clk,
  input  logic               reset,
  input  lc3b_mem_op         mem_op,
  input  lc3b_word           address,
  input  lc3b_word           wdata,
  input  logic               hold,
  mem_access_ctrl_if.master  dmem,
  output lc3b_word           load_data,
  output logic               done,
  output logic               stall_pipeline
);

  lc3b_mem_state state;
  // Pointer is always used word-aligned, so bit 0 is never kept.
  logic [14:0]   pointer_hi;

  lc3b_word      lane_wdata;
  logic [1:0]    lane_be;
  lc3b_word      lane_rdata;

  mem_byte_lane u_byte_lane (
    .mem_op      (mem_op),
    .byte_sel    (address[0]),
    .wdata       (wdata),
    .rdata       (dmem.dmem_rdata),
    .lane_wdata  (lane_wdata),
    .byte_enable (lane_be),
    .lane_rdata  (lane_rdata)
  );

  // Request outputs are a pure function of state and the (frozen) EX/MEM
  // inputs, so they stay stable until dmem_resp without extra registers.
  always_comb begin
    dmem.dmem_read        = 1'b0;
    dmem.dmem_write       = 1'b0;
    dmem.dmem_address     = {address[15:1], 1'b0};
    dmem.dmem_wdata       = lane_wdata;
    dmem.dmem_byte_enable = lane_be;
    case (state)
      ST_IDLE: begin
        if (mem_op != MEM_NONE) begin
          dmem.dmem_read  = first_is_read(mem_op);
          dmem.dmem_write = first_is_write(mem_op);
        end
      end
      ST_INDIRECT: begin
        dmem.dmem_address     = {pointer_hi, 1'b0};
        dmem.dmem_wdata       = wdata;
        dmem.dmem_byte_enable = 2'b11;
        dmem.dmem_read        = (mem_op == MEM_LDI);
        dmem.dmem_write       = (mem_op == MEM_STI);
      end
      default: ;
    endcase
  end

  assign done           = (state == ST_DONE);
  // Deliberately ignores hold: in DONE the access is finished and the
  // stall is released even while another source keeps the pipeline frozen.
  assign stall_pipeline = (mem_op != MEM_NONE) && (state != ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      pointer_hi <= '0;
      load_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if ((mem_op != MEM_NONE) && dmem.dmem_resp) begin
            if (is_indirect(mem_op)) begin
              pointer_hi <= dmem.dmem_rdata[15:1];
              state      <= ST_INDIRECT;
            end else begin
              if (is_direct_load(mem_op)) begin
                load_data <= lane_rdata;
              end
              state <= ST_DONE;
            end
          end
        end
        ST_INDIRECT: begin
          if (dmem.dmem_resp) begin
            if (mem_op == MEM_LDI) begin
              load_data <= dmem.dmem_rdata;
            end
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!hold) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset: clk input 1 (rising edge); reset input 1 (synchronous, active-high).
REQ-002 SHALL provide: mem_op input lc3b_mem_op -- memory op of the instruction in the EX/MEM register.
REQ-003 SHALL provide: address input 16 -- effective address from EX/MEM; wdata input 16 -- store source register value.
REQ-004 SHALL provide: hold input 1 -- pipeline frozen by another stall source this cycle.
REQ-005 SHALL provide: dmem_read output 1; dmem_write output 1; dmem_address output 16; dmem_wdata output 16; dmem_byte_enable output 2.
REQ-006 SHALL provide: dmem_rdata input 16; dmem_resp input 1 -- access complete this cycle.
REQ-007 SHALL provide: load_data output 16 -- result for MEM/WB; done output 1 -- access finished, load_data valid; stall_pipeline output 1 -- freezes all pipeline registers.

Function
REQ-008 SHALL implement FSM states IDLE, INDIRECT, DONE; reset state IDLE.
REQ-009 SHALL treat mem_op values: NONE, LDW, LDB, STW, STB, LDI, STI; TRAP vector fetch is issued as LDW.
REQ-010 IDLE with mem_op != NONE: SHALL issue the first access combinationally (read for LDW/LDB/LDI/STI, write for STW/STB).
REQ-011 Word accesses SHALL drive dmem_address = {address[15:1],0} and byte_enable = 11.
REQ-012 STB SHALL drive byte_enable = 10 if address[0]=1 else 01, and dmem_wdata = {wdata[7:0],wdata[7:0]}.
REQ-013 LDB SHALL select the byte by address[0] (1 = high byte) and sign-extend it to 16 bits.
REQ-014 IDLE + dmem_resp + op LDI/STI: SHALL latch dmem_rdata as the pointer and go to INDIRECT.
REQ-015 IDLE + dmem_resp + any other op: SHALL go to DONE; loads SHALL register the result into load_data on that edge.
REQ-016 INDIRECT: SHALL drive dmem_address = {pointer[15:1],0} with byte_enable 11.
REQ-017 INDIRECT: SHALL read for LDI and write wdata for STI; on dmem_resp it SHALL register the result (LDI) and go to DONE.
REQ-018 DONE: SHALL drive no request and assert done=1; next state SHALL be IDLE if hold=0, else stay in DONE; no access re-issued.
REQ-019 stall_pipeline SHALL be 1 iff mem_op != NONE and state != DONE, independent of hold.
REQ-020 dmem_read and dmem_write SHALL never both be 1; they SHALL remain stable, with a constant address, until dmem_resp.
REQ-021 Completion latency SHALL be one cycle after the final dmem_resp (done in cycle k+1 for resp in cycle k).
REQ-022 mem_op = NONE in IDLE: SHALL issue no request, stall_pipeline=0, done=0.
REQ-023 Stores SHALL leave load_data unchanged.

Reset
REQ-024 When reset is asserted at a clock edge, including mid-access, state SHALL become IDLE, the pointer and load_data SHALL become 0x0000, and done SHALL become 0.
REQ-025 The cycle after reset, outputs SHALL follow IDLE rules for the current mem_op; no abandoned request is resumed.

Structure
REQ-026 lc3b_mem_op enum and FSM state enum SHALL reside in package lc3b_types, alongside lc3b_word.
REQ-027 Byte-lane steering and sign extension SHALL be a combinational sub-module mem_byte_lane (STB replicate/enable, LDB select/SEXT).
REQ-028 Single module otherwise; no internal clock gating; all state SHALL be updated in one always_ff block.

Verification
REQ-029 LDW address=0x1235, rdata=0xBEEF, resp in 3rd cycle -> dmem_address=0x1234, BE=11; stall 1 for 3 cycles; done=1, load_data=0xBEEF in cycle 4.
REQ-030 LDB address=0x2001, rdata=0x80FF -> load_data=0xFF80; address=0x2000 -> 0xFFFF; rdata=0x7F00, address=0x2001 -> 0x007F.
REQ-031 STB address=0x3001, wdata=0x00A5 -> BE=10, dmem_wdata=0xA5A5, dmem_write=1, load_data unchanged.
REQ-032 LDI address=0x4000: mem[0x4000]=0x5001, mem[0x5000]=0x1234 -> second access at 0x5000; load_data=0x1234; stall_pipeline=1 throughout both accesses.
REQ-033 Hold=1 for 3 cycles in DONE -> done stays 1, no request issued, stall_pipeline=0; IDLE after hold drops.
REQ-034 Reset asserted in INDIRECT during STI -> next cycle no write to the pointer address, state IDLE, load_data=0x0000.
